pht_branch_predictor: RTL and testbench



---
 rtl/pht_branch_predictor_pkg.sv | 32 +++
 rtl/pht_branch_predictor_sat_counter.sv | 21 ++
 rtl/pht_branch_predictor.sv | 133 +++++++++++++
 tb/tb_pht_branch_predictor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pht_branch_predictor_pkg.sv
// Shared types, constants and index hash for the PHT direction predictor
// and related predictor tables.
package pht_branch_predictor_pkg;

   localparam int unsigned PC_WIDTH_DEF     = 32;
   localparam int unsigned INDEX_BITS_DEF   = 6;
   localparam int unsigned COUNTER_BITS_DEF = 2;
   localparam int unsigned HISTORY_BITS_DEF = 4;

   typedef logic [COUNTER_BITS_DEF-1:0] counter_t;
   typedef logic [INDEX_BITS_DEF-1:0]   index_t;
   typedef logic [HISTORY_BITS_DEF-1:0] history_t;

   typedef enum logic {
      BP_INIT  = 1'b0,
      BP_READY = 1'b1
   } bp_state_e;

   // Weakly-not-taken encoding for a counter of cbits width.
   function automatic logic [31:0] weak_nt_of(input int unsigned cbits);
      return 32'((32'd1 << (cbits - 32'd1)) - 32'd1);
   endfunction

   localparam counter_t WEAK_NT = COUNTER_BITS_DEF'(weak_nt_of(COUNTER_BITS_DEF));

   // gshare hash; callers pass the word-aligned PC field and zero-extended history.
   function automatic logic [31:0] pht_hash(input logic [31:0] pc_field,
                                            input logic [31:0] hist);
      return pc_field ^ hist;
   endfunction

endpackage

// File: rtl/pht_branch_predictor_sat_counter.sv
// Next value of one saturating up/down counter; shared by predictor tables.
module sat_counter_update #(
   parameter int unsigned COUNTER_BITS = 2
) (
   input  logic [COUNTER_BITS-1:0] value_i,
   input  logic                    taken_i,
   output logic [COUNTER_BITS-1:0] next_c_o
);

   localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

   always_comb begin
      next_c_o = value_i;
      if (taken_i) begin
         if (value_i != CNT_MAX) next_c_o = value_i + COUNTER_BITS'(1);
      end else begin
         if (value_i != '0) next_c_o = value_i - COUNTER_BITS'(1);
      end
   end

endmodule

// File: rtl/pht_branch_predictor.sv
// gshare direction predictor: table of saturating counters indexed by PC ^ GHR,
// swept to weakly-not-taken after reset or flush so it needs no reset itself.
module pht_branch_predictor
   import pht_branch_predictor_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
   parameter int unsigned INDEX_BITS   = INDEX_BITS_DEF,
   parameter int unsigned COUNTER_BITS = COUNTER_BITS_DEF,
   parameter int unsigned HISTORY_BITS = HISTORY_BITS_DEF,
   parameter bit          STATIC_MODE  = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [PC_WIDTH-1:0]               lookup_pc,
   output logic                              predict_taken,
   output logic [(HISTORY_BITS>0 ? HISTORY_BITS : 1)-1:0] predict_history,
   output logic                              predict_ready,
   input  logic                              update_valid,
   input  logic [PC_WIDTH-1:0]               update_pc,
   input  logic [(HISTORY_BITS>0 ? HISTORY_BITS : 1)-1:0] update_history,
   input  logic                              update_taken
);

   localparam int unsigned HW      = (HISTORY_BITS > 0) ? HISTORY_BITS : 1;
   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam logic [COUNTER_BITS-1:0] CNT_WEAK_NT = COUNTER_BITS'(weak_nt_of(COUNTER_BITS));

   bp_state_e               state_q, state_d;
   logic [INDEX_BITS-1:0]   sweep_ptr_q, sweep_ptr_d;
   logic [HW-1:0]           ghr_q;
   logic [COUNTER_BITS-1:0] table_q [ENTRIES];

   logic [INDEX_BITS-1:0]   lookup_idx, update_idx, tbl_waddr;
   logic [COUNTER_BITS-1:0] lookup_cnt, update_next, tbl_wdata;
   logic [HW-1:0]           upd_hist_eff;
   logic                    tbl_we;
   logic                    train_en;

   logic unused_bits;
   assign unused_bits = ^{lookup_pc, update_pc, update_history};

   assign upd_hist_eff = (HISTORY_BITS == 0) ? '0 : update_history;
   assign lookup_idx   = INDEX_BITS'(pht_hash(32'(lookup_pc[INDEX_BITS+1:2]), 32'(ghr_q)));
   assign update_idx   = INDEX_BITS'(pht_hash(32'(update_pc[INDEX_BITS+1:2]), 32'(upd_hist_eff)));
   assign lookup_cnt   = table_q[lookup_idx];
   assign train_en     = (state_q == BP_READY) && update_valid && !flush;

   sat_counter_update #(.COUNTER_BITS(COUNTER_BITS)) u_sat (
      .value_i  (table_q[update_idx]),
      .taken_i  (update_taken),
      .next_c_o (update_next)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BP_INIT;
         sweep_ptr_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_ptr_q <= sweep_ptr_d;
      end
   end

   // FSM next state; flush restarts the sweep from either state
   always_comb begin
      state_d     = state_q;
      sweep_ptr_d = sweep_ptr_q;
      case (state_q)
         BP_INIT: begin
            sweep_ptr_d = sweep_ptr_q + INDEX_BITS'(1);
            if (sweep_ptr_q == '1) state_d = BP_READY;
         end
         BP_READY: ;
         default:  state_d = BP_INIT;
      endcase
      if (flush) begin
         state_d     = BP_INIT;
         sweep_ptr_d = '0;
      end
   end

   // FSM outputs: table write-port mux and prediction gating
   always_comb begin
      tbl_we          = 1'b0;
      tbl_waddr       = update_idx;
      tbl_wdata       = update_next;
      predict_ready   = 1'b0;
      predict_taken   = 1'b0;
      predict_history = ghr_q;
      case (state_q)
         BP_INIT: begin
            tbl_we    = 1'b1;
            tbl_waddr = sweep_ptr_q;
            tbl_wdata = CNT_WEAK_NT;
         end
         BP_READY: begin
            tbl_we        = train_en;
            predict_ready = 1'b1;
            predict_taken = !STATIC_MODE && lookup_cnt[COUNTER_BITS-1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
   end

   // Non-speculative global history, shifted only by confirmed branches
   generate
      if (HISTORY_BITS == 0) begin : g_no_hist
         assign ghr_q = '0;
      end else begin : g_hist
         logic [HW-1:0] ghr_d;
         always_comb begin
            ghr_d = ghr_q;
            if (flush) begin
               ghr_d = '0;
            end else if (train_en) begin
               if (HW == 1) ghr_d = HW'(update_taken);
               else         ghr_d = HW'({ghr_q, update_taken});
            end
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) ghr_q <= '0;
            else     ghr_q <= ghr_d;
         end
      end
   endgenerate

endmodule

// File: tb/tb_pht_branch_predictor.sv
// Directed bench for pht_branch_predictor: default gshare, bimodal and static builds.
module tb_pht_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] lookup_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [3:0]  update_history;
   logic        update_taken;
   logic [0:0]  hist_zero = 1'b0;

   logic        taken_g, ready_g;
   logic [3:0]  hist_g;
   logic        taken_b, ready_b;
   logic [0:0]  hist_b;
   logic        taken_s, ready_s;
   logic [3:0]  hist_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pht_branch_predictor dut (
      .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
      .predict_taken(taken_g), .predict_history(hist_g), .predict_ready(ready_g),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_history(update_history), .update_taken(update_taken)
   );

   pht_branch_predictor #(.HISTORY_BITS(0)) dut_bim (
      .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
      .predict_taken(taken_b), .predict_history(hist_b), .predict_ready(ready_b),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_history(hist_zero), .update_taken(update_taken)
   );

   pht_branch_predictor #(.STATIC_MODE(1'b1)) dut_st (
      .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
      .predict_taken(taken_s), .predict_history(hist_s), .predict_ready(ready_s),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_history(update_history), .update_taken(update_taken)
   );

   typedef struct {
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic        exp_bim;
      logic [3:0]  exp_hist;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Expect exactly 64 not-ready cycles, then ready on the next one.
   task automatic wait_sweep(input string tag);
      for (int i = 0; i < 64; i++) begin
         settle();
         chk({tag, "_ready_low"}, 32'(ready_g), 32'd0);
         chk({tag, "_taken_low"}, 32'(taken_g), 32'd0);
         tick();
      end
      settle();
      chk({tag, "_ready_high"}, 32'(ready_g), 32'd1);
      chk({tag, "_ready_high_bim"}, 32'(ready_b), 32'd1);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [3:0] hist, input logic t);
      update_valid   = 1'b1;
      update_pc      = pc;
      update_history = hist;
      update_taken   = t;
      tick();
      update_valid   = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 4'b0000};
      vecs[1] = '{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 4'b0001};
      vecs[2] = '{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 4'b0011};
      vecs[3] = '{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 4'b0111};
      vecs[4] = '{32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 4'b1111};
      vecs[5] = '{32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 4'b1110};
      vecs[6] = '{32'h40, 1'b0, 32'h40, 1'b0, 1'b0, 4'b1100};
      vecs[7] = '{32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 4'b1100};
      vecs[8] = '{32'h80, 1'b0, 32'h80, 1'b0, 1'b1, 4'b1001};

      rst = 1'b1; flush = 1'b0; lookup_pc = 32'h40;
      update_valid = 1'b0; update_pc = 32'h40; update_history = 4'b0; update_taken = 1'b0;
      settle();
      chk("rst_ready", 32'(ready_g), 32'd0);
      chk("rst_taken", 32'(taken_g), 32'd0);
      chk("rst_hist",  32'(hist_g),  32'd0);
      tick();
      rst = 1'b0;

      // Taken updates during the initial sweep must be ignored
      update_valid = 1'b1; update_taken = 1'b1;
      wait_sweep("init");
      update_valid = 1'b0; update_taken = 1'b0;
      settle();
      chk("init_upd_ignored_bim", 32'(taken_b), 32'd0);
      chk("init_upd_ignored_hist", 32'(hist_g), 32'd0);
      tick();

      // Bimodal saturation, static forcing, history shifting, same-cycle read
      for (int i = 0; i < 9; i++) begin
         lookup_pc    = vecs[i].lpc;
         update_valid = vecs[i].uv;
         update_pc    = vecs[i].upc;
         update_taken = vecs[i].ut;
         settle();
         chk($sformatf("vec%0d_bim_taken", i), 32'(taken_b), 32'(vecs[i].exp_bim));
         chk($sformatf("vec%0d_bim_hist", i), 32'(hist_b), 32'd0);
         chk($sformatf("vec%0d_gs_hist", i), 32'(hist_g), 32'(vecs[i].exp_hist));
         chk($sformatf("vec%0d_st_hist", i), 32'(hist_s), 32'(vecs[i].exp_hist));
         chk($sformatf("vec%0d_st_taken", i), 32'(taken_s), 32'd0);
         tick();
      end
      update_valid = 1'b0;

      do_flush();
      wait_sweep("flush1");
      chk("flush1_hist", 32'(hist_g), 32'd0);
      tick();

      // gshare: entry 0x10 trained via pc 0x44 ^ history 0001
      upd(32'h44, 4'b0001, 1'b1);
      upd(32'h44, 4'b0001, 1'b1);
      for (int i = 0; i < 4; i++) upd(32'hFC, 4'b0000, 1'b0);
      lookup_pc = 32'h40;
      settle();
      chk("gs_hist_0000", 32'(hist_g), 32'd0);
      chk("gs_idx10_taken", 32'(taken_g), 32'd1);
      tick();
      upd(32'hFC, 4'b0000, 1'b1);
      settle();
      chk("gs_hist_0001", 32'(hist_g), 32'd1);
      chk("gs_idx11_weak", 32'(taken_g), 32'd0);
      lookup_pc = 32'h44;
      settle();
      chk("gs_pc44_idx10", 32'(taken_g), 32'd1);
      tick();

      // Flush with a same-cycle update: the update is dropped, table re-swept
      update_valid = 1'b1; update_pc = 32'h44; update_history = 4'b0001; update_taken = 1'b1;
      do_flush();
      update_valid = 1'b0;
      wait_sweep("flush2");
      chk("flush2_hist", 32'(hist_g), 32'd0);
      lookup_pc = 32'h40;
      settle();
      chk("flush2_idx10_weak", 32'(taken_g), 32'd0);
      chk("flush2_hist_after", 32'(hist_g), 32'd0);
      tick();

      // Async reset mid-sweep at ptr=20 restarts the full sweep
      do_flush();
      repeat (20) tick();
      rst = 1'b1;
      settle();
      chk("midrst_ready", 32'(ready_g), 32'd0);
      chk("midrst_hist", 32'(hist_g), 32'd0);
      rst = 1'b0;
      wait_sweep("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
